// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: func codes, command
// field positions, FSM encoding and small decode helpers.
package alu_pkg;

    localparam int NREG = 8;

    typedef enum logic [3:0] {
        F_ADD   = 4'd0,
        F_SUB   = 4'd1,
        F_MUL   = 4'd2,
        F_DIV   = 4'd3,
        F_AND   = 4'd4,
        F_OR    = 4'd5,
        F_XOR   = 4'd6,
        F_NOT   = 4'd7,
        F_PASSA = 4'd8,
        F_PASSB = 4'd9,
        F_SHL   = 4'd10,
        F_SHR   = 4'd11,
        F_SRA   = 4'd12,
        F_ROL   = 4'd13,
        F_ROR   = 4'd14,
        F_HAMM  = 4'd15
    } func_t;

    // cmd_data field positions
    localparam int FUNC_MSB = 31;
    localparam int FUNC_LSB = 28;
    localparam int IMM_BIT  = 27;
    localparam int DST_MSB  = 26;
    localparam int DST_LSB  = 24;
    localparam int SRCA_MSB = 22;
    localparam int SRCA_LSB = 20;
    localparam int SRCB_MSB = 18;
    localparam int SRCB_LSB = 16;
    localparam int IMMA_MSB = 15;
    localparam int IMMA_LSB = 8;
    localparam int IMMB_MSB = 7;
    localparam int IMMB_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Decoded command; bits 23 and 19 of the raw word are reserved.
    typedef struct packed {
        func_t      func;
        logic       imm;
        logic [2:0] dst;
        logic [2:0] srca;
        logic [2:0] srcb;
        logic [7:0] imma;
        logic [7:0] immb;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [31:0] d);
        cmd_t c;
        c.func = func_t'(d[FUNC_MSB:FUNC_LSB]);
        c.imm  = d[IMM_BIT];
        c.dst  = d[DST_MSB:DST_LSB];
        c.srca = d[SRCA_MSB:SRCA_LSB];
        c.srcb = d[SRCB_MSB:SRCB_LSB];
        c.imma = d[IMMA_MSB:IMMA_LSB];
        c.immb = d[IMMB_MSB:IMMB_LSB];
        return c;
    endfunction

    // ALU command word: func in the top nibble, operands in the low half.
    function automatic logic [31:0] alu_word(input func_t f, input logic [7:0] a,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = '0;
        w[FUNC_MSB:FUNC_LSB] = f;
        w[IMMA_MSB:IMMA_LSB] = a;
        w[IMMB_MSB:IMMB_LSB] = b;
        return w;
    endfunction

    // Shift funcs 10-12 are flagged as illegal commands.
    function automatic logic is_illegal(input func_t f);
        return f inside {F_SHL, F_SHR, F_SRA};
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command handshake bundle between a command source and the sequencer.
interface alu_cmd_sequencer_if;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/alu_regfile.sv
// 8x8 register file: two operand read ports, one debug read port, one
// synchronous write port, synchronous clear.
module alu_regfile #(
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [7:0]              wdata,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [7:0]              rdata_a,
    output logic [7:0]              rdata_b,
    output logic [7:0]              dbg_data
);

    logic [NREG-1:0][7:0] mem;

    // Storage: clear on reset, otherwise single write per cycle
    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    // Reads see current contents; a same-cycle write shows up next cycle.
    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequencer owning the 8-bit ALU: accepts a command, fetches operands,
// drives the ALU for an op-dependent number of cycles, writes back.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DIV_WAIT  = 4,   // EXEC cycles for divide, >= 1
    parameter int EXEC_WAIT = 1,   // EXEC cycles for other ops, >= 1
    parameter int NREG      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   cmd,
    output logic [31:0]          alu_cmd,
    input  logic [7:0]           alu_res,
    input  logic [2:0]           rd_addr,
    output logic [7:0]           rd_data,
    output logic                 done,
    output logic [7:0]           result,
    output logic                 err_div0,
    output logic                 err_illegal
);

    localparam logic [7:0] DIV_CNT  = 8'(DIV_WAIT);
    localparam logic [7:0] EXEC_CNT = 8'(EXEC_WAIT);

    state_t      state, state_nx;
    logic [31:0] cmd_q;
    cmd_t        c;
    logic [7:0]  cnt;
    logic [7:0]  wb_val;
    logic        nowrite;
    logic [7:0]  rf_a, rf_b;
    logic [7:0]  opa, opb;
    logic        ready;
    logic        rf_we;
    logic        accept;
    logic        load_ill, load_div0;
    logic        unused_rsvd;

    assign c           = decode_cmd(cmd_q);
    assign unused_rsvd = ^{cmd_q[23], cmd_q[19]};
    assign opa         = c.imm ? c.imma : rf_a;
    assign opb         = c.imm ? c.immb : rf_b;
    assign load_ill    = is_illegal(c.func);
    assign load_div0   = !load_ill && (c.func == F_DIV) && (opb == 8'h00);
    assign accept      = cmd.cmd_valid && ready;
    assign cmd.cmd_ready = ready;

    alu_regfile #(.NREG(NREG)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (c.dst),
        .wdata    (wb_val),
        .raddr_a  (c.srca),
        .raddr_b  (c.srcb),
        .dbg_addr (rd_addr),
        .rdata_a  (rf_a),
        .rdata_b  (rf_b),
        .dbg_data (rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state: error cases bypass EXEC and retire straight from LOAD
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_LOAD;
            S_LOAD: state_nx = (load_ill || load_div0) ? S_WB : S_EXEC;
            S_EXEC: if (cnt == 8'd1) state_nx = S_WB;
            S_WB:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs: ready only when idle, done/write only in WB; reset masks both
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        rf_we = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE:  ready = 1'b1;
                S_WB: begin
                    done  = 1'b1;
                    rf_we = !nowrite;
                end
                default: ;
            endcase
        end
    end

    // Datapath: command latch, ALU word, wait counter, writeback value, flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= '0;
            alu_cmd     <= '0;
            cnt         <= '0;
            wb_val      <= '0;
            nowrite     <= 1'b0;
            result      <= '0;
            err_div0    <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept)
                        cmd_q <= cmd.cmd_data;
                end
                S_LOAD: begin
                    alu_cmd <= alu_word(c.func, opa, opb);
                    nowrite <= 1'b0;
                    if (load_ill) begin
                        err_illegal <= 1'b1;
                        nowrite     <= 1'b1;
                    end else if (load_div0) begin
                        err_div0 <= 1'b1;
                        wb_val   <= 8'hFF;
                    end else begin
                        cnt <= (c.func == F_DIV) ? DIV_CNT : EXEC_CNT;
                    end
                end
                S_EXEC: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1)
                        wb_val <= alu_res;
                end
                S_WB: begin
                    if (!nowrite)
                        result <= wb_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench: directed scenarios plus random commands against a
// register-array reference model; the external ALU is modelled here too.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int DIV_WAIT  = 4;
    localparam int EXEC_WAIT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_cmd;
    logic [7:0]  alu_res;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        done;
    logic [7:0]  result;
    logic        err_div0, err_illegal;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_reg [8];
    logic       m_div0, m_ill;
    logic [7:0] m_res;

    alu_cmd_sequencer_if cif();

    alu_cmd_sequencer #(.DIV_WAIT(DIV_WAIT), .EXEC_WAIT(EXEC_WAIT), .NREG(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cif),
        .alu_cmd     (alu_cmd),
        .alu_res     (alu_res),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .done        (done),
        .result      (result),
        .err_div0    (err_div0),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [3:0] f, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [15:0] p, t;
        case (f)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  begin p = a * b; return p[7:0]; end
            4'd3:  return (b == 0) ? 8'hFF : a / b;
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd7:  return ~a;
            4'd8:  return a;
            4'd9:  return b;
            4'd10: return a << b[2:0];
            4'd11: return a >> b[2:0];
            4'd12: return $signed(a) >>> b[2:0];
            4'd13: begin t = {a, a} << b[2:0]; return t[15:8]; end
            4'd14: begin t = {a, a} >> b[2:0]; return t[7:0]; end
            default: return 8'($countones(a ^ b));
        endcase
    endfunction

    always_comb alu_res = alu_ref(alu_cmd[31:28], alu_cmd[15:8], alu_cmd[7:0]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            chk(tag, {24'h0, rd_data}, {24'h0, m_reg[i]});
        end
    endtask

    // Issue one command, track its lifetime, and compare against the model.
    // keep=1 leaves cmd_valid high (with junk data) so the next call is
    // accepted in the first idle cycle after WB.
    task automatic do_cmd(input logic [3:0] f, input logic imm, input logic [2:0] dst,
                          input logic [2:0] sa, input logic [2:0] sb,
                          input logic [7:0] ia, input logic [7:0] ib, input bit keep);
        logic [31:0] w, exp_alu;
        logic [7:0]  a, b, wv;
        logic        ill, d0;
        int          exp_lat, lat, n;
        bit          busy_ok, stable_ok;

        w   = {f, imm, dst, 1'b0, sa, 1'b0, sb, ia, ib};
        a   = imm ? ia : m_reg[sa];
        b   = imm ? ib : m_reg[sb];
        ill = (f == 4'd10) || (f == 4'd11) || (f == 4'd12);
        d0  = !ill && (f == 4'd3) && (b == 8'h00);
        exp_lat = (ill || d0) ? 2 : ((f == 4'd3) ? 2 + DIV_WAIT : 2 + EXEC_WAIT);
        wv      = d0 ? 8'hFF : alu_ref(f, a, b);
        exp_alu = {f, 12'h000, a, b};

        n = 0;
        while (cif.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_cmd", {31'h0, cif.cmd_ready}, 32'd1);
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = w;
        @(posedge clk);
        #1;
        cif.cmd_valid = keep;
        cif.cmd_data  = $urandom;

        lat = 0; busy_ok = 1'b1; stable_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cif.cmd_ready !== 1'b0) busy_ok = 1'b0;
            if (k >= 2 && alu_cmd !== exp_alu) stable_ok = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, exp_lat);
        chk("ready_low_busy", {31'h0, busy_ok}, 32'd1);
        chk("alu_cmd_stable", {31'h0, stable_ok}, 32'd1);

        // same-address read during WB still returns the old value
        rd_addr = dst;
        #1;
        chk("wb_read_old", {24'h0, rd_data}, {24'h0, m_reg[dst]});

        if (!ill) begin
            m_reg[dst] = wv;
            m_res      = wv;
        end
        if (ill) m_ill  = 1'b1;
        if (d0)  m_div0 = 1'b1;

        @(negedge clk);
        #1;
        chk("done_single", {31'h0, done}, 32'd0);
        chk("ready_idle", {31'h0, cif.cmd_ready}, 32'd1);
        chk("result", {24'h0, result}, {24'h0, m_res});
        chk("err_div0", {31'h0, err_div0}, {31'h0, m_div0});
        chk("err_illegal", {31'h0, err_illegal}, {31'h0, m_ill});
        chk("reg_new", {24'h0, rd_data}, {24'h0, m_reg[dst]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         keep;
        logic [3:0] f;
        logic [7:0] ib;
        int         n;

        foreach (m_reg[i]) m_reg[i] = 8'h00;
        m_div0 = 1'b0; m_ill = 1'b0; m_res = 8'h00;
        cif.cmd_valid = 1'b0;
        cif.cmd_data  = '0;
        rd_addr       = 3'd0;

        // reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'h0, cif.cmd_ready}, 32'd0);
        chk("rst_alu_cmd", alu_cmd, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_result", {24'h0, result}, 32'd0);
        chk("rst_div0", {31'h0, err_div0}, 32'd0);
        chk("rst_illegal", {31'h0, err_illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'h0, cif.cmd_ready}, 32'd1);
        check_regs("rst_regs");

        // immediate add 5+3 into r1
        do_cmd(4'd0, 1'b1, 3'd1, 3'd0, 3'd0, 8'h05, 8'h03, 1'b0);
        chk("t1_result", {24'h0, result}, 32'h08);
        rd_addr = 3'd1; #1;
        chk("t1_r1", {24'h0, rd_data}, 32'h08);

        // load-immediate r2, r3 then wrapping register add r2 = r2 + r3
        do_cmd(4'd8, 1'b1, 3'd2, 3'd0, 3'd0, 8'hC8, 8'h00, 1'b0);
        do_cmd(4'd8, 1'b1, 3'd3, 3'd0, 3'd0, 8'h64, 8'h00, 1'b0);
        do_cmd(4'd0, 1'b0, 3'd2, 3'd2, 3'd3, 8'h00, 8'h00, 1'b0);
        rd_addr = 3'd2; #1;
        chk("t2_r2_wrap", {24'h0, rd_data}, 32'h2C);

        // divide 100/7
        do_cmd(4'd3, 1'b1, 3'd7, 3'd0, 3'd0, 8'h64, 8'h07, 1'b0);
        chk("t3_result", {24'h0, result}, 32'h0E);

        // divide by zero, then a normal add
        do_cmd(4'd3, 1'b1, 3'd4, 3'd0, 3'd0, 8'h10, 8'h00, 1'b0);
        chk("t4_div0", {31'h0, err_div0}, 32'd1);
        rd_addr = 3'd4; #1;
        chk("t4_r4", {24'h0, rd_data}, 32'hFF);
        do_cmd(4'd0, 1'b1, 3'd6, 3'd0, 3'd0, 8'h21, 8'h12, 1'b0);
        chk("t4_add_after", {24'h0, result}, 32'h33);
        chk("t4_div0_sticky", {31'h0, err_div0}, 32'd1);

        // unimplemented shift op
        do_cmd(4'd11, 1'b1, 3'd5, 3'd0, 3'd0, 8'h80, 8'h01, 1'b0);
        chk("t5_illegal", {31'h0, err_illegal}, 32'd1);
        chk("t5_result_held", {24'h0, result}, 32'h33);
        check_regs("t5_regs");

        // reset during EXEC of a divide
        n = 0;
        while (cif.cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = {4'd3, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0, 8'hC8, 8'h05};
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_ready_in_rst", {31'h0, cif.cmd_ready}, 32'd0);
        chk("t6_no_done_in_rst", {31'h0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        foreach (m_reg[i]) m_reg[i] = 8'h00;
        m_div0 = 1'b0; m_ill = 1'b0; m_res = 8'h00;
        chk("t6_ready", {31'h0, cif.cmd_ready}, 32'd1);
        chk("t6_div0_clr", {31'h0, err_div0}, 32'd0);
        chk("t6_ill_clr", {31'h0, err_illegal}, 32'd0);
        chk("t6_result_clr", {24'h0, result}, 32'd0);
        check_regs("t6_regs");
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done !== 1'b0) n++;
        end
        chk("t6_no_done_after", n, 0);

        // back-to-back with cmd_valid held high
        do_cmd(4'd8, 1'b1, 3'd0, 3'd0, 3'd0, 8'h3C, 8'h00, 1'b1);
        do_cmd(4'd1, 1'b0, 3'd1, 3'd0, 3'd4, 8'h00, 8'h00, 1'b1);
        do_cmd(4'd2, 1'b1, 3'd2, 3'd0, 3'd0, 8'h13, 8'h11, 1'b0);
        chk("t6_b2b_result", {24'h0, result}, 32'h43);
        check_regs("b2b_regs");

        // random commands
        for (int i = 0; i < 60; i++) begin
            f  = 4'($urandom_range(0, 15));
            ib = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            keep = (i != 59) && ($urandom_range(0, 1) == 1);
            do_cmd(f, 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   8'($urandom), ib, keep);
            if (!keep) check_regs("rand_regs");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
